// File: rtl/add_iter_pkg.sv
// add_iter_pkg: definitions shared by the iterative adder, the ripple
// subtractor and the condition-code logic of the SEQ ALU.
//   state_e  : IDLE / RUN / DONE sequencing states
//   flags_t  : x86-style flag bundle (of, zf, sf)
//   DEF_WIDTH, DEF_SLICE : default operand width and bits per iteration
//   idx_width() : width of a counter able to hold 0..n-1 (at least 1 bit)
package add_iter_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_SLICE = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic of;
    logic zf;
    logic sf;
  } flags_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_iter_if.sv
// add_iter_if: request/result bundle of the iterative adder.
//   start, a, b          : request from the master (ALU sequencer)
//   busy, done           : status from the adder
//   sum, c_out           : arithmetic result
//   overflow, zf, sf     : condition flags (0 when flags are compiled out)
// Handshake: a request is accepted on a rising edge where start=1 and the
// adder is idle (busy=0, done=0); start at any other time is dropped, not
// queued. Results are valid while done=1 and hold until the next accepted
// start. a and b need only be stable on the accepting edge.
interface add_iter_if #(
  parameter int WIDTH = 64
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;
  logic             zf;
  logic             sf;

  modport master (
    output start, a, b,
    input  busy, done, sum, c_out, overflow, zf, sf
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, c_out, overflow, zf, sf
  );
endinterface

// File: rtl/add_iter_slice.sv
// full_adder : one-bit full adder cell.
// add_slice  : SLICE-bit ripple adder built from full_adder cells.
//   a, b   : slice operands
//   ci     : carry in
//   s      : slice sum
//   co     : carry out of the slice MSB
//   c_msb  : carry into the slice MSB (gives signed overflow on the top slice)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module add_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co,
  output logic             c_msb
);
  logic [SLICE:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co    = c[SLICE];
  assign c_msb = c[SLICE-1];
endmodule

// File: rtl/add_iter.sv
// add_iter: iterative WIDTH-bit adder, one SLICE-bit chunk per clock, LSB
// first, carry held in a register between chunks.
//   clk, rst  : clock and asynchronous active-high reset
//   bus       : add_iter_if slave (start/a/b in; busy/done/sum/c_out/flags out)
//   dbg_state : current FSM state, for checkers
// WIDTH must be a multiple of SLICE. Latency is WIDTH/SLICE cycles from the
// accepting edge to done; one operation per WIDTH/SLICE+2 cycles.
// Build option ADD_ITER_FLAGS_EN: when defined, overflow/zf/sf are computed
// and registered at the DONE transition; otherwise they are tied to 0.
module add_iter
  import add_iter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic   clk,
  input  logic   rst,
  add_iter_if.slave bus,
  output state_e dbg_state
);

  localparam int N     = WIDTH / SLICE;
  localparam int IDX_W = idx_width(N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             c_out_q, c_out_d;
  flags_t           flags_q, flags_d;

  // Current slice datapath.
  logic [SLICE-1:0] a_sl, b_sl, s_sl;
  logic             co_sl, cmsb_sl;
  logic [WIDTH-1:0] sum_run;

  assign a_sl = a_q[idx_q*SLICE +: SLICE];
  assign b_sl = b_q[idx_q*SLICE +: SLICE];

  add_slice #(.SLICE(SLICE)) u_slice (
    .a     (a_sl),
    .b     (b_sl),
    .ci    (carry_q),
    .s     (s_sl),
    .co    (co_sl),
    .c_msb (cmsb_sl)
  );

  // Sum register with the current slice merged in; on the last slice this
  // is the final result, which the flags are derived from.
  always_comb begin
    sum_run = sum_q;
    sum_run[idx_q*SLICE +: SLICE] = s_sl;
  end

`ifndef ADD_ITER_FLAGS_EN
  logic unused_cmsb;
  assign unused_cmsb = cmsb_sl;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    c_out_d = c_out_q;
    flags_d = flags_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sum_d   = '0;
          carry_d = 1'b0;
          idx_d   = '0;
          c_out_d = 1'b0;
          flags_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d   = sum_run;
        carry_d = co_sl;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          c_out_d = co_sl;
`ifdef ADD_ITER_FLAGS_EN
          flags_d.of = cmsb_sl ^ co_sl;
          flags_d.zf = (sum_run == '0);
          flags_d.sf = sum_run[WIDTH-1];
`endif
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      c_out_q <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      c_out_q <= c_out_d;
      flags_q <= flags_d;
    end
  end

  assign bus.busy     = (state_q == ST_RUN);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.sum      = sum_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = flags_q.of;
  assign bus.zf       = flags_q.zf;
  assign bus.sf       = flags_q.sf;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_add_iter.sv
// tb_add_iter: self-checking bench for add_iter (WIDTH=64, SLICE=8).
// Drives at #1 after the rising edge and samples there as well.
module tb_add_iter;
  import add_iter_pkg::*;

  localparam int W   = 64;
  localparam int RW  = W + 4;   // {sum, c_out, overflow, zf, sf}
  localparam int LAT = 8;

  logic   clk;
  logic   rst;
  state_e dbg_state;

  add_iter_if #(.WIDTH(W)) bus ();

  add_iter #(.WIDTH(W), .SLICE(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  logic [RW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [RW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         ov, z, sg;
    full = {1'b0, a} + {1'b0, b};
    s    = full[W-1:0];
`ifdef ADD_ITER_FLAGS_EN
    ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    z  = (s == '0);
    sg = s[W-1];
`else
    ov = 1'b0;
    z  = 1'b0;
    sg = 1'b0;
`endif
    return {s, full[W], ov, z, sg};
  endfunction

  function automatic logic [RW-1:0] observed();
    return {bus.sum, bus.c_out, bus.overflow, bus.zf, bus.sf};
  endfunction

  // ---------------- driver tasks ----------------
  // Presents a request for one edge (the caller ensures the DUT is idle) and
  // records the expected result.
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Waits for done, counting edges since the accepting edge; bounded.
  task automatic wait_done(output int cycles, output logic seen);
    seen   = 1'b0;
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [RW-1:0] o;
    o = observed();
    checks++;
    if (o !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got res=%h busy=%b done=%b, want all 0", o, bus.busy, bus.done);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state: got %0d, want %0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va[6];
    logic [W-1:0] vb[6];
    int           cyc;
    logic         seen;
    logic [RW-1:0] e;
    va[0] = 64'd5;                  vb[0] = 64'd3;
    va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'd1;
    va[2] = 64'h7FFF_FFFF_FFFF_FFFF; vb[2] = 64'd1;
    va[3] = 64'h8000_0000_0000_0000; vb[3] = 64'h8000_0000_0000_0000;
    va[4] = {$urandom(), $urandom()}; vb[4] = {$urandom(), $urandom()};
    va[5] = {$urandom(), $urandom()}; vb[5] = 64'h00FF_00FF_00FF_00FF;
    for (int t = 0; t < 6; t++) begin
      drive_start(va[t], vb[t]);
      checks++;
      if (bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL vec%0d_busy: got %b, want 1", t, bus.busy);
      end
      wait_done(cyc, seen);
      checks++;
      if (!seen || cyc != LAT) begin
        failures++;
        $display("FAIL vec%0d_latency: got %0d seen=%b, want %0d", t, cyc, seen, LAT);
      end
      if (seen) begin
        checks++;
        if (bus.busy !== 1'b0) begin
          failures++;
          $display("FAIL vec%0d_busy_at_done: got %b, want 0", t, bus.busy);
        end
        e = exp_q.pop_front();
        checks++;
        if (observed() !== e) begin
          failures++;
          $display("FAIL vec%0d_result: got %h, want %h", t, observed(), e);
        end
        // Results hold after the done pulse.
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0 || observed() !== e) begin
          failures++;
          $display("FAIL vec%0d_hold: done=%b res=%h, want done=0 res=%h", t, bus.done, observed(), e);
        end
      end else begin
        exp_q.delete();
      end
      idle_cycles(1);
    end
  endtask

  task automatic test_ignore_start();
    int   cyc;
    logic seen;
    logic [RW-1:0] e;
    int   extra_done;
    drive_start(64'd1, 64'd1);
    idle_cycles(2);               // now in RUN cycle 3
    bus.a = 64'd9; bus.b = 64'd9; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(cyc, seen);
    checks++;
    if (!seen || cyc != LAT - 3) begin
      failures++;
      $display("FAIL ignore_latency: got %0d seen=%b, want %0d", cyc, seen, LAT - 3);
    end
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e) begin
      failures++;
      $display("FAIL ignore_result: got %h, want %h", observed(), e);
    end
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) extra_done++;
    end
    checks++;
    if (extra_done != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL ignore_no_second_op: got %0d active cycles, want 0", extra_done);
    end
  endtask

  task automatic test_back_to_back();
    int   cyc;
    logic seen;
    logic [RW-1:0] e;
    drive_start(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
    wait_done(cyc, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || observed() !== e) begin
      failures++;
      $display("FAIL b2b_first: got %h seen=%b, want %h", observed(), seen, e);
    end
    // Hold start from the DONE cycle on: the DONE edge must drop it, the
    // following edge must accept it.
    bus.a = 64'd100; bus.b = 64'd23; bus.start = 1'b1;
    exp_q.push_back(model(64'd100, 64'd23));
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL b2b_done_ignores: busy=%b state=%0d, want 0/%0d", bus.busy, dbg_state, ST_IDLE);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept: busy=%b, want 1", bus.busy);
    end
    wait_done(cyc, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || cyc != LAT || observed() !== e) begin
      failures++;
      $display("FAIL b2b_second: got %h cyc=%0d, want %h cyc=%0d", observed(), cyc, e, LAT);
    end
    idle_cycles(1);
  endtask

  task automatic test_reset_abort();
    int   cyc;
    logic seen;
    logic [RW-1:0] e;
    int   stray;
    drive_start(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    idle_cycles(3);               // RUN cycle 4
    rst = 1'b1;
    #1;
    checks++;
    if (observed() !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL abort_outputs: res=%h busy=%b done=%b state=%0d, want 0", observed(), bus.busy, bus.done, dbg_state);
    end
    exp_q.delete();
    // start goes high while still in reset and must be taken on the first
    // clean edge.
    bus.a = 64'd10; bus.b = 64'd20; bus.start = 1'b1;
    exp_q.push_back(model(64'd10, 64'd20));
    @(posedge clk); #1;
    stray = bus.done ? 1 : 0;
    rst = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || stray != 0) begin
      failures++;
      $display("FAIL abort_restart_accept: busy=%b stray_done=%0d, want 1/0", bus.busy, stray);
    end
    wait_done(cyc, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || cyc != LAT || observed() !== e) begin
      failures++;
      $display("FAIL abort_restart_result: got %h cyc=%0d, want %h cyc=%0d", observed(), cyc, e, LAT);
    end
    idle_cycles(1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    idle_cycles(3);
    test_reset();
    rst = 1'b0;
    idle_cycles(1);
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
